// File: rtl/mult4_pkg.sv
// Shared types and sizing for the mult4 shift-and-add multiplier.
package mult4_pkg;

  localparam int unsigned MULT4_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult4_state_t;

  // Accumulator carries four guard bits above the product width.
  function automatic int unsigned acc_width(input int unsigned w);
    return 2 * w + 4;
  endfunction

endpackage

// File: rtl/mult4_step.sv
// One shift-and-add iteration: conditionally add the shifted multiplicand.
module mult4_step
  import mult4_pkg::*;
#(
  parameter int unsigned WIDTH = MULT4_WIDTH
) (
  input  logic [2*WIDTH-1:0] partial,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic               mplier_lsb,
  output logic [2*WIDTH-1:0] partial_next
);

  always_comb partial_next = mplier_lsb ? partial + mcand : partial;

endmodule

// File: rtl/mult4_seq.sv
// Iterative WIDTH x WIDTH unsigned multiplier with start/busy/done handshake.
// Optional running accumulator of products when MULT4_ACC_EN is defined.
module mult4_seq
  import mult4_pkg::*;
#(
  parameter int unsigned WIDTH = MULT4_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
`ifdef MULT4_ACC_EN
  ,
  input  logic                        acc_clr,
  output logic [acc_width(WIDTH)-1:0] acc
`endif
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mult4_state_t     state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    partial_q, partial_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    product_d;
  logic             busy_d, done_d;
  logic [PW-1:0]    step_sum;
  logic             last_step;

`ifdef MULT4_ACC_EN
  localparam int unsigned AW = acc_width(WIDTH);
  logic [AW-1:0] acc_d;
`endif

  mult4_step #(.WIDTH(WIDTH)) u_step (
    .partial      (partial_q),
    .mcand        (mcand_q),
    .mplier_lsb   (mplier_q[0]),
    .partial_next (step_sum)
  );

  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    partial_d = partial_q;
    cnt_d     = cnt_q;
    product_d = product;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d   = {{WIDTH{1'b0}}, a};
          mplier_d  = b;
          partial_d = '0;
          cnt_d     = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        partial_d = step_sum;
        mcand_d   = mcand_q << 1;
        mplier_d  = mplier_q >> 1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (last_step) begin
          product_d = step_sum;
          done_d    = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
`ifdef MULT4_ACC_EN
    acc_d = acc;
    if (state_q == RUN && last_step) acc_d = acc + AW'(step_sum);
    if (acc_clr) acc_d = '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      partial_q <= '0;
      cnt_q     <= '0;
      product   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef MULT4_ACC_EN
      acc       <= '0;
`endif
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      partial_q <= partial_d;
      cnt_q     <= cnt_d;
      product   <= product_d;
      busy      <= busy_d;
      done      <= done_d;
`ifdef MULT4_ACC_EN
      acc       <= acc_d;
`endif
    end
  end

endmodule
